branch_sequencer: RTL and testbench
===================================

Name: branch_sequencer

Overview:
- Multi-cycle program-counter controller for the 18-bit CPU.
- Accepts one control-flow request per handshake: sequential step, unconditional jump, or conditional branch.
- For branches, it registers both operands, derives zero/positive/negative flags in a dedicated compare cycle, and resolves the branch condition.
- It then updates the PC and runs a request/acknowledge fetch handshake with instruction memory before accepting the next request.

Parameters:
- DATA_W, 18, operand width for branch comparison.
- ADDR_W, 12, program-counter / instruction-address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  control-flow request present.
- req_ready  output  1  block idle and able to accept a request.
- req_kind  input  2  00 step, 01 jump, 10 branch, 11 reserved (treated as step).
- b_choice  input  3  branch condition: 000 EQ, 001 GT, 010 LT, 011 GE, 100 LE, 101-111 never-taken.
- op_a  input  DATA_W  first comparison operand.
- op_b  input  DATA_W  second comparison operand.
- target  input  ADDR_W  jump/branch destination.
- pc  output  ADDR_W  current program counter.
- taken  output  1  one-cycle pulse when a jump or branch redirects the PC.
- flush  output  1  one-cycle pulse, coincident with taken; kills the younger instruction in decode.
- fetch_req  output  1  instruction fetch request for address pc.
- fetch_ack  input  1  instruction memory accepted fetch_req.
- flags  output  3  last registered {zf,pf,nf}, for debug.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - state=IDLE, pc=RESET_PC, flags=000.
  - taken=0, flush=0, fetch_req=0.
  - req_ready=1 is driven combinationally from state=IDLE.
  - Deasserting reset mid-operation always restarts from IDLE; there is no automatic first fetch.
- States: IDLE, CMP, RESOLVE, FETCH.
- IDLE:
  - req_ready=1.
  - On req_valid=1, capture req_kind, b_choice, op_a, op_b and target into internal registers.
  - kind=10 goes to CMP; kind 00, 01 or 11 goes to RESOLVE.
  - Captured values are stable for the rest of the transaction; input changes are ignored until the block returns to IDLE.
- CMP, exactly one cycle:
  - Unsigned compare of the captured operands.
  - flags <= {a==b, a>b, a<b}. Exactly one bit is set.
  - Always goes to RESOLVE.
- RESOLVE, exactly one cycle.
  - Branch: cond = EQ zf, GT pf, LT nf, GE pf|zf, LE nf|zf, reserved codes 0.
  - Jump: cond=1.
  - Step: cond=0.
  - If cond=1: pc <= target, taken=1, flush=1 this cycle.
  - If cond=0: pc <= pc+1, wrapping modulo 2^ADDR_W (max value steps to 0).
  - flags are not altered for a step or jump.
  - Always goes to FETCH.
- FETCH:
  - fetch_req=1, presenting the new pc.
  - Remain in FETCH while fetch_ack=0.
  - When fetch_ack=1, go to IDLE next cycle; fetch_req drops that same edge.
- Latency, request accepted to IDLE with zero-wait memory:
  - Branch: 4 cycles.
  - Step or jump: 3 cycles.
- req_valid during a non-IDLE state is not accepted (req_ready=0); the requester holds it.
- fetch_ack while not in FETCH is ignored.
- target==pc on a taken branch still pulses taken/flush and refetches.

Decomposition:
- Shared package cpu_branch_pkg:
  - req_kind codes.
  - b_choice encodings (BR_EQ..BR_LE).
  - FSM state encoding.
  - DATA_W/ADDR_W defaults.
- Sub-module branch_cond_eval:
  - Purely combinational flags + b_choice -> cond.
  - Reused by the single-cycle CPU path.
- Compare and flag registers stay in branch_sequencer.

Test Plan:
- Reset/step:
  - Stimulus: hold rst_n low, release; then one step request with fetch_ack tied 1.
  - Response: pc=0 with req_ready=1 after release; after the step, pc=1, taken never asserted, fetch_req high exactly 1 cycle, req_ready returns 3 cycles after acceptance.
- Branch taken / not taken:
  - Branch GE, op_a=18'd5, op_b=18'd5, target=12'h040 -> flags=100, pc=040, taken and flush 1-cycle pulse in RESOLVE.
  - Same with op_a=4, op_b=5 -> flags=001, pc=old+1, no taken.
- Unsigned and reserved conditions:
  - Branch GT, op_a=18'h3FFFF, op_b=1 -> taken (unsigned).
  - Branch with b_choice=3'b110 -> not taken, pc+1.
- Fetch backpressure:
  - Jump to 12'h123, fetch_ack held 0 for 5 cycles -> fetch_req stays high with pc=123 all 5 cycles.
  - New req_valid held during wait -> not accepted until IDLE.
- Wrap and reset mid-op:
  - Step from pc=12'hFFF -> pc=000.
  - Assert rst_n=0 during FETCH -> fetch_req drops immediately, pc=RESET_PC, state IDLE.

Source files
------------

// File: rtl/cpu_branch_pkg.sv
// Shared encodings for the branch sequencer and the single-cycle CPU condition path.
// Holds request kinds, branch-condition codes, FSM states and default widths.
package cpu_branch_pkg;

  localparam int DATA_W_DEF = 18;
  localparam int ADDR_W_DEF = 12;

  typedef enum logic [1:0] {
    KIND_STEP   = 2'b00,
    KIND_JUMP   = 2'b01,
    KIND_BRANCH = 2'b10,
    KIND_RSVD   = 2'b11
  } req_kind_e;

  typedef enum logic [2:0] {
    BR_EQ = 3'b000,
    BR_GT = 3'b001,
    BR_LT = 3'b010,
    BR_GE = 3'b011,
    BR_LE = 3'b100
  } br_choice_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMP,
    ST_RESOLVE,
    ST_FETCH
  } seq_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluation from {zf,pf,nf} and the condition code.
// Codes outside BR_EQ..BR_LE never take the branch.
module branch_cond_eval
  import cpu_branch_pkg::*;
(
  input  logic [2:0] flags,
  input  logic [2:0] b_choice,
  output logic       cond
);

  logic zf, pf, nf;

  assign {zf, pf, nf} = flags;

  always_comb begin
    cond = 1'b0;
    case (b_choice)
      BR_EQ:   cond = zf;
      BR_GT:   cond = pf;
      BR_LT:   cond = nf;
      BR_GE:   cond = pf | zf;
      BR_LE:   cond = nf | zf;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Multi-cycle PC controller: accepts step/jump/branch requests, resolves them,
// updates the PC and handshakes the instruction fetch before going idle again.
//
// state      | meaning
// IDLE       | req_ready high, capture the next request
// CMP        | unsigned compare of captured operands into flags (branches only)
// RESOLVE    | evaluate condition, update pc, pulse taken/flush on redirect
// FETCH      | fetch_req high for pc until fetch_ack
module branch_sequencer
  import cpu_branch_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_kind,
  input  logic [2:0]        b_choice,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic              taken,
  output logic              flush,
  output logic              fetch_req,
  input  logic              fetch_ack,
  output logic [2:0]        flags
);

  seq_state_e        state, state_nxt;
  req_kind_e         kind_q;
  logic [2:0]        choice_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [ADDR_W-1:0] target_q;
  logic [2:0]        flags_q;
  logic              cap_en;
  logic              br_cond;
  logic              redirect;

  branch_cond_eval u_cond (
    .flags    (flags_q),
    .b_choice (choice_q),
    .cond     (br_cond)
  );

  always_comb begin
    redirect = 1'b0;
    case (kind_q)
      KIND_BRANCH: redirect = br_cond;
      KIND_JUMP:   redirect = 1'b1;
      default:     redirect = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    taken     = 1'b0;
    flush     = 1'b0;
    fetch_req = 1'b0;
    cap_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cap_en    = 1'b1;
          state_nxt = (req_kind == KIND_BRANCH) ? ST_CMP : ST_RESOLVE;
        end
      end
      ST_CMP:     state_nxt = ST_RESOLVE;
      ST_RESOLVE: begin
        taken     = redirect;
        flush     = redirect;
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Captured request fields stay frozen until the block is idle again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      flags_q  <= 3'b000;
      kind_q   <= KIND_STEP;
      choice_q <= 3'b000;
      a_q      <= '0;
      b_q      <= '0;
      target_q <= '0;
    end else begin
      if (cap_en) begin
        kind_q   <= req_kind_e'(req_kind);
        choice_q <= b_choice;
        a_q      <= op_a;
        b_q      <= op_b;
        target_q <= target;
      end
      if (state == ST_CMP) flags_q <= {a_q == b_q, a_q > b_q, a_q < b_q};
      if (state == ST_RESOLVE) pc <= redirect ? target_q : pc + 1'b1;
    end
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: table of requests with hand-computed PC,
// flags, redirect and latency, plus reset and mid-fetch reset checks.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [2:0]  b_choice;
  logic [17:0] op_a, op_b;
  logic [11:0] target;
  logic [11:0] pc;
  logic        taken, flush, fetch_req, fetch_ack;
  logic [2:0]  flags;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  choice;
    logic [17:0] a;
    logic [17:0] b;
    logic [11:0] tgt;
    int          delay;
    bit          hold;
    logic [11:0] exp_pc;
    logic [2:0]  exp_flags;
    int          exp_taken;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  branch_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_kind  (req_kind),
    .b_choice  (b_choice),
    .op_a      (op_a),
    .op_b      (op_b),
    .target    (target),
    .pc        (pc),
    .taken     (taken),
    .flush     (flush),
    .fetch_req (fetch_req),
    .fetch_ack (fetch_ack),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request from IDLE and follow it back to IDLE, one sample per cycle.
  task automatic run_txn(input int idx, input vec_t v);
    int   lat, tk, fl, fc, waits;
    logic pc_ok;
    chk($sformatf("r%0d_ready", idx), req_ready, 1);
    req_kind  = v.kind;
    b_choice  = v.choice;
    op_a      = v.a;
    op_b      = v.b;
    target    = v.tgt;
    req_valid = 1'b1;
    fetch_ack = (v.delay == 0);
    @(posedge clk); #1;
    if (v.hold) begin
      req_kind = 2'b00;
      target   = 12'hABC;
      op_a     = 18'd1;
      op_b     = 18'd2;
    end else begin
      req_valid = 1'b0;
    end
    lat = 1; tk = 0; fl = 0; fc = 0; waits = 0; pc_ok = 1'b1;
    while (!req_ready && lat < 40) begin
      if (taken) tk++;
      if (flush) fl++;
      if (fetch_req) begin
        fc++;
        if (pc !== v.exp_pc) pc_ok = 1'b0;
        if (waits < v.delay) begin
          fetch_ack = 1'b0;
          waits++;
        end else begin
          fetch_ack = 1'b1;
        end
      end
      @(posedge clk); #1;
      lat++;
    end
    fetch_ack = 1'b1;
    chk($sformatf("r%0d_done", idx), req_ready, 1);
    chk($sformatf("r%0d_pc", idx), pc, v.exp_pc);
    chk($sformatf("r%0d_flags", idx), flags, v.exp_flags);
    chk($sformatf("r%0d_taken", idx), tk, v.exp_taken);
    chk($sformatf("r%0d_flush", idx), fl, v.exp_taken);
    chk($sformatf("r%0d_fetch_cycles", idx), fc, v.delay + 1);
    chk($sformatf("r%0d_fetch_pc", idx), pc_ok, 1);
    chk($sformatf("r%0d_latency", idx), lat, v.exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            kind   ch      a          b      tgt     dly hold  pc      flags  tk lat
    vecs.push_back('{2'b00, 3'b000, 18'd0,     18'd0, 12'h555, 0, 0, 12'h001, 3'b000, 0, 3});
    vecs.push_back('{2'b10, 3'b011, 18'd5,     18'd5, 12'h040, 0, 0, 12'h040, 3'b100, 1, 4});
    vecs.push_back('{2'b10, 3'b011, 18'd4,     18'd5, 12'h200, 0, 0, 12'h041, 3'b001, 0, 4});
    vecs.push_back('{2'b10, 3'b001, 18'h3FFFF, 18'd1, 12'h0AB, 0, 0, 12'h0AB, 3'b010, 1, 4});
    vecs.push_back('{2'b10, 3'b110, 18'd7,     18'd7, 12'h300, 0, 0, 12'h0AC, 3'b100, 0, 4});
    vecs.push_back('{2'b10, 3'b000, 18'd9,     18'd8, 12'h0F0, 0, 0, 12'h0AD, 3'b010, 0, 4});
    vecs.push_back('{2'b10, 3'b010, 18'd1,     18'd2, 12'h020, 0, 0, 12'h020, 3'b001, 1, 4});
    vecs.push_back('{2'b10, 3'b100, 18'd3,     18'd3, 12'h030, 0, 0, 12'h030, 3'b100, 1, 4});
    vecs.push_back('{2'b10, 3'b100, 18'd9,     18'd3, 12'h777, 0, 0, 12'h031, 3'b010, 0, 4});
    vecs.push_back('{2'b11, 3'b001, 18'd9,     18'd3, 12'h400, 0, 0, 12'h032, 3'b010, 0, 3});
    vecs.push_back('{2'b01, 3'b000, 18'd0,     18'd0, 12'h123, 5, 1, 12'h123, 3'b010, 1, 8});
    vecs.push_back('{2'b00, 3'b000, 18'd0,     18'd0, 12'h000, 0, 0, 12'h124, 3'b010, 0, 3});
    vecs.push_back('{2'b10, 3'b000, 18'd0,     18'd0, 12'h124, 0, 0, 12'h124, 3'b100, 1, 4});
    vecs.push_back('{2'b01, 3'b110, 18'd0,     18'd0, 12'hFFF, 0, 0, 12'hFFF, 3'b100, 1, 3});
    vecs.push_back('{2'b00, 3'b000, 18'd0,     18'd0, 12'h321, 0, 0, 12'h000, 3'b100, 0, 3});
    vecs.push_back('{2'b11, 3'b000, 18'd0,     18'd0, 12'h666, 0, 0, 12'h001, 3'b100, 0, 3});

    rst_n = 1'b0; req_valid = 1'b0; req_kind = 2'b00; b_choice = 3'b000;
    op_a = '0; op_b = '0; target = '0; fetch_ack = 1'b1;
    #23;
    chk("rst_pc", pc, 12'h000);
    chk("rst_ready", req_ready, 1);
    chk("rst_fetch_req", fetch_req, 0);
    chk("rst_taken", {taken, flush}, 2'b00);
    chk("rst_flags", flags, 3'b000);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_pc", pc, 12'h000);
    chk("post_rst_ready", req_ready, 1);

    for (int i = 0; i < vecs.size(); i++) run_txn(i, vecs[i]);

    fetch_ack = 1'b0;
    req_kind = 2'b01; target = 12'h222; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_fetch_req", fetch_req, 1);
    chk("mid_pc", pc, 12'h222);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_fetch_req", fetch_req, 0);
    chk("mid_rst_pc", pc, 12'h000);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_flags", flags, 3'b000);
    @(negedge clk) rst_n = 1'b1;
    fetch_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("no_auto_fetch", fetch_req, 0);
    chk("no_auto_pc", pc, 12'h000);
    run_txn(99, '{2'b00, 3'b000, 18'd0, 18'd0, 12'h0EE, 0, 0, 12'h001, 3'b000, 0, 3});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
